// File: rtl/led_pkg.sv
// Shared encodings for the LED flow sequencer: command opcodes and FSM states.
package led_pkg;

  typedef enum logic [1:0] {
    OP_STOP  = 2'b00,
    OP_FLOW  = 2'b01,
    OP_BLINK = 2'b10,
    OP_SET   = 2'b11
  } led_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_FLOW  = 2'b10,
    ST_BLINK = 2'b11
  } led_state_e;

  localparam int DIV_W = 4;

endpackage

// File: rtl/tick_gen.sv
// Base-tick prescaler: counts 0..TICK_CYCLES-1 while enabled, held at 0 otherwise.
module tick_gen #(
  parameter int TICK_CYCLES = 25_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      count <= '0;
    end else if (!en || count == CNT_MAX) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  // Ungated: count can only reach CNT_MAX after en has been high.
  assign tick = (count == CNT_MAX);

endmodule

// File: rtl/led_flow_ctrl.sv
// Command-driven LED sequencer: stop / rotate / blink / static set with
// prescaled step timing and a per-command step divider.
module led_flow_ctrl
  import led_pkg::*;
#(
  parameter int TICK_CYCLES = 25_000_000,
  parameter int LED_W       = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
  // cmd_ready is low only during the single LOAD cycle; cmd_valid may be held.
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LED_W-1:0] cmd_data,
  input  logic [DIV_W-1:0] cmd_period,
  output logic [LED_W-1:0] led,
  output logic             step_pulse,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam logic [LED_W-1:0] LED_ONE = {{(LED_W-1){1'b0}}, 1'b1};

  led_state_e       state, state_nxt;
  led_op_e          op_q;
  logic [LED_W-1:0] data_q;
  logic [LED_W-1:0] mask_q, mask_nxt;
  logic [LED_W-1:0] led_nxt;
  logic [DIV_W-1:0] period_q;
  logic [DIV_W-1:0] div_q;
  logic             accept;
  logic             running;
  logic             tick;
  logic             step;

  assign cmd_ready = (state != ST_LOAD);
  assign accept    = cmd_valid && cmd_ready;
  assign running   = (state == ST_FLOW) || (state == ST_BLINK);
  assign step      = running && tick && (div_q == period_q);
  assign state_dbg = state;

  // Prescaler is cleared on the accepting edge so LOAD always starts from 0.
  tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_gen (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .en       (running && !accept),
    .tick     (tick)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == ST_FLOW) || (state_nxt == ST_BLINK);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD: begin
        case (op_q)
          OP_FLOW:  state_nxt = ST_FLOW;
          OP_BLINK: state_nxt = ST_BLINK;
          default:  state_nxt = ST_IDLE;
        endcase
      end
      default: begin
        if (accept) state_nxt = ST_LOAD;
      end
    endcase
  end

  // LOAD takes priority; a step on the accepting edge is applied first and
  // then overwritten by the LOAD edge that follows.
  always_comb begin
    led_nxt  = led;
    mask_nxt = mask_q;
    if (state == ST_LOAD) begin
      case (op_q)
        OP_SET:  led_nxt = data_q;
        OP_FLOW: led_nxt = (data_q == '0) ? LED_ONE : data_q;
        OP_BLINK: begin
          led_nxt  = data_q;
          mask_nxt = (data_q == '0) ? '1 : data_q;
        end
        default: led_nxt = led;
      endcase
    end else if (step) begin
      if (state == ST_FLOW) led_nxt = {led[LED_W-2:0], led[LED_W-1]};
      else                  led_nxt = led ^ mask_q;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      led        <= LED_ONE;
      mask_q     <= '1;
      step_pulse <= 1'b0;
      op_q       <= OP_STOP;
      data_q     <= '0;
      period_q   <= '0;
      div_q      <= '0;
    end else begin
      led        <= led_nxt;
      mask_q     <= mask_nxt;
      step_pulse <= step;
      if (accept) begin
        op_q     <= led_op_e'(cmd_op);
        data_q   <= cmd_data;
        period_q <= cmd_period;
      end
      if (!running || accept) begin
        div_q <= '0;
      end else if (tick) begin
        div_q <= step ? '0 : div_q + DIV_W'(1);
      end
    end
  end

endmodule
